// File: rtl/cnna_pkg.sv
// Shared types for the cnna buffer streaming blocks: read-engine states and FIFO depth.
package cnna_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry register FIFO: zero-latency head, push/pop in the same cycle, synchronous flush.
// Push into a full FIFO and pop from an empty one are ignored; the owner's credit logic prevents both.
module rd_skid_fifo
  import cnna_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_push,
  input  logic [WIDTH-1:0] I_push_dat,
  input  logic             I_pop,
  input  logic             I_flush,
  output logic [1:0]       O_count,
  output logic [WIDTH-1:0] O_head
);

  logic [WIDTH-1:0] r_mem [RD_FIFO_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = I_pop && (r_count != 2'd0);
  assign w_push = I_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else if (I_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= I_push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign O_count = r_count;
  assign O_head  = r_mem[r_rptr];

endmodule

// File: rtl/spram_rd_stream.sv
// Streams a contiguous spram address range out as valid/ready beats, hiding the 1-cycle read latency.
// Optional RD_STREAM_LAST_EN adds O_last, flagging the final beat of each transfer.
module spram_rd_stream
  import cnna_pkg::*;
#(
  parameter int ASIZE = 10,
  parameter int DSIZE = 32,
  parameter int LSIZE = ASIZE + 1
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_start,
  input  logic [ASIZE-1:0] I_base,
  input  logic [LSIZE-1:0] I_len,
  input  logic             I_abort,
  output logic             O_busy,
  output logic             O_done,
  output logic             O_ram_en,
  output logic [ASIZE-1:0] O_ram_addr,
  input  logic [DSIZE-1:0] I_ram_data,
  output logic             O_valid,
  output logic [DSIZE-1:0] O_data,
`ifdef RD_STREAM_LAST_EN
  output logic             O_last,
`endif
  input  logic             I_ready
);

`ifdef RD_STREAM_LAST_EN
  localparam int FW = DSIZE + 1;
`else
  localparam int FW = DSIZE;
`endif

  rd_state_t        r_state;
  logic [ASIZE-1:0] r_addr;
  logic [LSIZE-1:0] r_remain;
  logic             r_inflight;
  logic             r_done;
  logic [1:0]       w_count;
  logic [FW-1:0]    w_head;
  logic [FW-1:0]    w_push_dat;
  logic             w_valid;
  logic             w_pop;
  logic [2:0]       w_occ_after;
  logic             w_issue;

  assign w_valid = (w_count != 2'd0);
  assign w_pop   = w_valid && I_ready;

  // Words that will be buffered or in flight after this cycle's pop; an issue needs one free slot.
  assign w_occ_after = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue     = (r_state == RUN) && (r_remain != '0) && (w_occ_after < 3'd2) && !I_abort;

`ifdef RD_STREAM_LAST_EN
  logic r_inflight_last;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight_last <= w_issue && (r_remain == LSIZE'(1));
    end
  end

  assign w_push_dat = {r_inflight_last, I_ram_data};
  assign O_last     = w_valid && w_head[DSIZE];
`else
  assign w_push_dat = I_ram_data;
`endif

  rd_skid_fifo #(.WIDTH(FW)) u_fifo (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_push     (r_inflight),
    .I_push_dat (w_push_dat),
    .I_pop      (w_pop),
    .I_flush    (I_abort),
    .O_count    (w_count),
    .O_head     (w_head)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      if (I_abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (I_start) begin
              r_addr   <= I_base;
              r_remain <= I_len;
              if (I_len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= RUN;
              end
            end
          end
          RUN: begin
            if (w_issue && (r_remain == LSIZE'(1))) begin
              r_state <= DRAIN;
            end
          end
          DRAIN: begin
            // Finish on the edge that retires the last buffered word.
            if (!r_inflight && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop))) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign O_busy     = (r_state != IDLE);
  assign O_done     = r_done;
  assign O_ram_en   = w_issue;
  assign O_ram_addr = r_addr;
  assign O_valid    = w_valid;
  assign O_data     = w_head[DSIZE-1:0];

endmodule

// File: tb/tb_spram_rd_stream.sv
// Bench for spram_rd_stream: table of directed transfers plus random ones, checked against an address-order model.
module tb_spram_rd_stream;

  localparam int ASIZE = 10;
  localparam int DSIZE = 32;
  localparam int LSIZE = ASIZE + 1;

  logic             I_clk = 1'b0;
  logic             I_rst_n;
  logic             I_start;
  logic [ASIZE-1:0] I_base;
  logic [LSIZE-1:0] I_len;
  logic             I_abort;
  logic             O_busy;
  logic             O_done;
  logic             O_ram_en;
  logic [ASIZE-1:0] O_ram_addr;
  logic [DSIZE-1:0] I_ram_data;
  logic             O_valid;
  logic [DSIZE-1:0] O_data;
  logic             O_last;
  logic             I_ready;

  int vectors     = 0;
  int miscompares = 0;

  spram_rd_stream #(.ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE)) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_start    (I_start),
    .I_base     (I_base),
    .I_len      (I_len),
    .I_abort    (I_abort),
    .O_busy     (O_busy),
    .O_done     (O_done),
    .O_ram_en   (O_ram_en),
    .O_ram_addr (O_ram_addr),
    .I_ram_data (I_ram_data),
    .O_valid    (O_valid),
    .O_data     (O_data),
`ifdef RD_STREAM_LAST_EN
    .O_last     (O_last),
`endif
    .I_ready    (I_ready)
  );

`ifndef RD_STREAM_LAST_EN
  assign O_last = 1'b0;
`endif

  always #5 I_clk = ~I_clk;

  function automatic logic [DSIZE-1:0] ram_word(input logic [ASIZE-1:0] a);
    logic [DSIZE-1:0] x;
    x = {22'd0, a};
    return (x * 32'h9E3779B1) ^ 32'h5A5A_0000 ^ x;
  endfunction

  function automatic logic [ASIZE-1:0] addr_of(input logic [ASIZE-1:0] base, input int i);
    logic [ASIZE-1:0] off;
    off = i[ASIZE-1:0];
    return base + off;
  endfunction

  // Behavioural single-port RAM with registered read data.
  always @(posedge I_clk) begin
    if (O_ram_en) I_ram_data <= ram_word(O_ram_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ASIZE-1:0] base;
    int               len;
    int               rmode;       // 0 ready high, 1 ready 1-0-0-1, 2 random
    int               abort_after; // abort once this many beats accepted, -1 never
    int               start_mid;   // pulse a stray start while busy
    int               exp_first;   // sample index of first O_valid, -1 none allowed
    int               exp_done;    // sample index of O_done, -1 none, -2 any
  } vec_t;

  function automatic vec_t mk(input logic [ASIZE-1:0] b, input int l, input int rm, input int ab,
                              input int sm, input int ef, input int ed);
    vec_t v;
    v.base = b; v.len = l; v.rmode = rm; v.abort_after = ab;
    v.start_mid = sm; v.exp_first = ef; v.exp_done = ed;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int issued = 0;
    int beats = 0;
    int k = 0;
    int outstanding;
    int budget;
    bit done_seen = 0;
    bit first_seen = 0;
    bit aborted = 0;
    bit stall = 0;
    logic [DSIZE-1:0] stall_dat = '0;
    budget = 4 * v.len + 40;
    @(negedge I_clk);
    I_start = 1'b1;
    I_base  = v.base;
    I_len   = LSIZE'(v.len);
    I_ready = 1'b0;
    while (k < budget && !done_seen && !aborted) begin
      @(negedge I_clk);
      I_start = (v.start_mid != 0) && (k == 5);
      I_base  = v.base ^ 10'h155;
      I_len   = LSIZE'(3);
      case (v.rmode)
        0:       I_ready = 1'b1;
        1:       I_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: I_ready = 1'($urandom_range(0, 1));
      endcase
      if (v.abort_after >= 0 && beats == v.abort_after) begin
        I_abort = 1'b1;
        I_start = 1'b1;
        I_ready = 1'b0;
        @(negedge I_clk);
        I_abort = 1'b0;
        I_start = 1'b0;
        #1;
        chk("abort_valid", O_valid, 0);
        chk("abort_busy", O_busy, 0);
        chk("abort_ram_en", O_ram_en, 0);
        for (int j = 0; j < 4; j++) begin
          chk("abort_no_done", O_done, 0);
          chk("abort_no_last", O_last, 0);
          @(negedge I_clk);
        end
        aborted = 1;
      end else begin
        #1;
        outstanding = issued - beats;
        if (O_ram_en) begin
          chk("ram_addr", O_ram_addr, addr_of(v.base, issued));
          chk("credit", ((outstanding - int'(O_valid && I_ready)) < 2), 1);
          chk("extra_issue", (issued < v.len), 1);
          issued++;
        end
        if (stall) begin
          chk("hold_valid", O_valid, 1);
          chk("hold_data", O_data, stall_dat);
        end
        if (O_valid && !first_seen) begin
          first_seen = 1;
          if (v.exp_first >= 0) chk("first_valid_cycle", k, v.exp_first);
          else chk("unexpected_valid", 1, 0);
        end
        if (O_valid && I_ready) begin
          chk("data", O_data, ram_word(addr_of(v.base, beats)));
`ifdef RD_STREAM_LAST_EN
          chk("last", O_last, (beats == v.len - 1));
`endif
          beats++;
        end
        stall = O_valid && !I_ready;
        stall_dat = O_data;
        if (O_done) begin
          done_seen = 1;
          if (v.exp_done >= 0) chk("done_cycle", k, v.exp_done);
          else if (v.exp_done == -1) chk("unexpected_done", 1, 0);
          chk("beats_at_done", beats, v.len);
          chk("busy_at_done", O_busy, 0);
          chk("valid_at_done", O_valid, 0);
        end
        k++;
      end
    end
    if (!aborted && !done_seen) chk("done_timeout", 0, 1);
    I_ready = 1'b0;
    repeat (2) @(negedge I_clk);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = mk(10'h010,    4, 0, -1, 0,  2,    6);
    vecs[1] = mk(10'h3FE,    4, 0, -1, 0,  2,    6);
    vecs[2] = mk(10'h100,   16, 1, -1, 1,  2,   -2);
    vecs[3] = mk(10'h055,    0, 0, -1, 0, -1,    0);
    vecs[4] = mk(10'h200,    8, 0,  3, 0,  2,   -1);
    vecs[5] = mk(10'h020,    5, 0, -1, 0,  2,    7);
    vecs[6] = mk(10'h000, 1024, 0, -1, 0,  2, 1026);

    I_rst_n = 1'b0; I_start = 1'b0; I_base = '0; I_len = '0;
    I_abort = 1'b0; I_ready = 1'b0; I_ram_data = '0;
    #12;
    chk("rst_busy", O_busy, 0);
    chk("rst_done", O_done, 0);
    chk("rst_ram_en", O_ram_en, 0);
    chk("rst_valid", O_valid, 0);
    chk("rst_addr", O_ram_addr, 0);
    chk("rst_data", O_data, 0);
    chk("rst_last", O_last, 0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (2) @(negedge I_clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Asynchronous reset while the FIFO holds stalled words.
    @(negedge I_clk);
    I_start = 1'b1; I_base = 10'h3F0; I_len = LSIZE'(8); I_ready = 1'b0;
    @(negedge I_clk);
    I_start = 1'b0;
    repeat (4) @(negedge I_clk);
    chk("pre_rst_valid", O_valid, 1);
    #2;
    I_rst_n = 1'b0;
    #1;
    chk("arst_busy", O_busy, 0);
    chk("arst_done", O_done, 0);
    chk("arst_ram_en", O_ram_en, 0);
    chk("arst_valid", O_valid, 0);
    chk("arst_addr", O_ram_addr, 0);
    chk("arst_data", O_data, 0);
    chk("arst_last", O_last, 0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (2) @(negedge I_clk);
    run_vec(vecs[5]);

    for (int r = 0; r < 12; r++) begin
      int l;
      l = $urandom_range(0, 40);
      run_vec(mk(10'($urandom), l, 2, -1, 0, (l == 0) ? -1 : 2, (l == 0) ? 0 : -2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
